nco_phase_gen: RTL and testbench
================================

# nco_phase_gen

Numerically controlled oscillator front end for the audio synth path. It produces the 15-bit phase word that feeds the triangle waveform stage (phase in, 12-bit sample out). The block generates the sample-rate strobe, accumulates a programmable frequency control word (FCW) once per sample, and double-buffers FCW updates so a new pitch takes effect only on a sample boundary. Note gating ends a note at the next phase wrap, so the waveform stops at phase 0 with no click.

## Interface
- `ACC_WIDTH`, 24: phase accumulator width.
- `PHASE_WIDTH`, 15: output phase width, taken from the top bits of the accumulator.
- `SAMPLE_DIV`, 2500: clk cycles per sample (125 MHz / 50 kHz).

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `fcw_in` in, ACC_WIDTH: new frequency control word.
- `fcw_valid` in, 1: `fcw_in` is offered.
- `fcw_ready` out, 1: shadow register is free; the load happens when `fcw_valid && fcw_ready`.
- `note_on` in, 1: level-sensitive note gate.
- `phase_reset` in, 1: synchronous clear of the accumulator.
- `sample_tick` out, 1: one-cycle sample strobe.
- `phase` out, PHASE_WIDTH: `acc[ACC_WIDTH-1 -: PHASE_WIDTH]`, registered.
- `phase_valid` out, 1: one-cycle pulse, high when `phase` has just updated.
- `active` out, 1: state is not IDLE.

## Operation
- **Sample divider:** counter runs 0..SAMPLE_DIV-1 and wraps. `tick` is internal, high when count == SAMPLE_DIV-1. It free-runs in every state.
- **FCW buffering:**
  - A handshake writes `shadow` and sets `pending`. `fcw_ready = !pending`.
  - On `tick` with `pending`: `fcw_active <= shadow` and `pending` clears.
  - The addition on that same tick uses the old `fcw_active`.
- **States:**
  - IDLE: `acc` held at 0. On `note_on` go to RUN; no accumulation occurs that cycle.
  - RUN: on `tick`, `acc <= acc + fcw_active`, modulo 2^ACC_WIDTH. If `!note_on` go to DRAIN.
  - DRAIN: on `tick`, accumulate as in RUN.
    - If the addition carries out of bit ACC_WIDTH-1: `acc <= 0`, go to IDLE.
    - If `fcw_active == 0` on `tick`: `acc <= 0`, go to IDLE.
    - If `note_on` reasserts: go to RUN with no `acc` change.
- **`phase_reset`:** `acc <= 0` on the next edge. It has priority over a same-cycle `tick` accumulation. It does not touch the divider, state, or FCW registers.
- **Width rule:** exactly one increment per tick, no saturation. Phase step per sample = `fcw_active >> (ACC_WIDTH-PHASE_WIDTH)`, with the fractional bits kept in `acc`.

## Timing
- **Reset values:** counter 0, `acc` 0, `phase` 0, `fcw_active` 0, `shadow` 0, `pending` 0, state IDLE. Outputs: `fcw_ready` 1, `sample_tick` 0, `phase_valid` 0, `active` 0.
- **`sample_tick`:** registered, asserted the cycle after the counter reaches SAMPLE_DIV-1.
- **`phase` and `phase_valid`:**
  - `phase` updates on the same edge as `sample_tick`, in RUN/DRAIN only. `phase_valid` pulses with it.
  - In IDLE, `phase_valid` stays 0 and `phase` reads 0.
- **Latency:** a FCW offered before tick N is used first by the addition at tick N+1.
- **Pipeline to the waveform stage:** the downstream triangle stage adds 2 cycles (LUT, then output register). Consumers sample `wave` 2 cycles after `phase_valid`.
- **`rst` mid-note:** immediate return to the reset values above, including any pending FCW being discarded.
- **`fcw_valid` while `pending`:** ignored; the offering side must hold it until `fcw_ready`.

## Structure
- **Shared package `synth_pkg`:**
  - State enum IDLE/RUN/DRAIN.
  - Default constants `SYNTH_ACC_WIDTH=24`, `SYNTH_PHASE_WIDTH=15`, `SYNTH_SAMPLE_DIV=2500`.
- **Sub-module `sample_tick_gen`:** parameter DIV, outputs `tick`. It is reused by the other voice blocks.
- FCW shadow, accumulator and FSM stay in the top module.

## Test plan
Bench uses SAMPLE_DIV=4.

1. **Reset:** hold `rst` for 3 cycles → `fcw_ready`=1, `phase`=0, `active`=0, `phase_valid`=0. After release, `sample_tick` pulses every 4 cycles.
2. **Steady increment:** load FCW 0x100000, `note_on`=1 → first tick applies it. Subsequent `phase_valid` pulses show `phase` = 0x800, 0x1000, 0x1800…, wrapping 0x7800 → 0x0000 after 16 steps.
3. **Back-pressure:** offer 0x200000 and immediately 0x080000 → the second offer is stalled (`fcw_ready`=0) until the next tick. The step becomes 0x1000, then 0x400, one tick after each apply.
4. **Release:** drop `note_on` at `phase`=0x5000 with FCW 0x100000 → `phase` continues 0x5800…0x7800. The next wrap gives `acc`=0, `active`=0, and `phase_valid` stops.
5. **Boundary events:**
   - Re-raise `note_on` during DRAIN → back to RUN with no discontinuity in `phase`.
   - DRAIN with FCW 0 → IDLE on the next tick.
6. **Priority:** `phase_reset` on a tick cycle → `phase`=0 on that update. Mid-note `rst` → `pending` cleared and a new FCW is accepted immediately.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the audio synth voice blocks.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } nco_state_e;

  localparam int SYNTH_ACC_WIDTH   = 24;
  localparam int SYNTH_PHASE_WIDTH = 15;
  localparam int SYNTH_SAMPLE_DIV  = 2500;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider; tick is high for the last count of each period.
module sample_tick_gen
  import synth_pkg::*;
#(
  parameter int DIV = SYNTH_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO front end: double-buffered FCW, per-sample phase accumulation and
// note gating that releases only at a phase wrap.
module nco_phase_gen
  import synth_pkg::*;
#(
  parameter int ACC_WIDTH   = SYNTH_ACC_WIDTH,
  parameter int PHASE_WIDTH = SYNTH_PHASE_WIDTH,
  parameter int SAMPLE_DIV  = SYNTH_SAMPLE_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_WIDTH-1:0]   fcw_in,
  input  logic                   fcw_valid,
  output logic                   fcw_ready,
  input  logic                   note_on,
  input  logic                   phase_reset,
  output logic                   sample_tick,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   active
);

  logic tick;

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  nco_state_e             state_q;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   fcw_q, shadow_q;
  logic                   pending_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   phase_valid_q, sample_tick_q;
  logic [ACC_WIDTH:0]     sum_w;
  logic                   drain_stop;

  assign sum_w = {1'b0, acc_q} + {1'b0, fcw_q};
  // A draining note stops at the wrap, or immediately if it can never wrap.
  assign drain_stop = tick && !note_on && (sum_w[ACC_WIDTH] || (fcw_q == '0));

  always_comb begin
    acc_d = acc_q;
    unique case (state_q)
      IDLE:    acc_d = '0;
      RUN:     if (tick) acc_d = sum_w[ACC_WIDTH-1:0];
      DRAIN:   if (tick) acc_d = drain_stop ? '0 : sum_w[ACC_WIDTH-1:0];
      default: acc_d = '0;
    endcase
    if (phase_reset) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      sample_tick_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      sample_tick_q <= tick;
      phase_valid_q <= tick && (state_q != IDLE);
      if (tick && (state_q != IDLE)) phase_q <= acc_d[ACC_WIDTH-1 -: PHASE_WIDTH];
      unique case (state_q)
        IDLE:    if (note_on) state_q <= RUN;
        RUN:     if (!note_on) state_q <= DRAIN;
        DRAIN: begin
          if (note_on)         state_q <= RUN;
          else if (drain_stop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The shadow only moves to the live FCW on a sample boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcw_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else if (tick && pending_q) begin
      fcw_q     <= shadow_q;
      pending_q <= 1'b0;
    end else if (fcw_valid && !pending_q) begin
      shadow_q  <= fcw_in;
      pending_q <= 1'b1;
    end
  end

  assign fcw_ready   = !pending_q;
  assign sample_tick = sample_tick_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign active      = (state_q != IDLE);

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: vector table, corner sequences, random vs model.
module tb_nco_phase_gen;

  localparam int AW  = 24;
  localparam int PW  = 15;
  localparam int DIV = 4;
  localparam longint MOD = longint'(1) << AW;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1, fcw_valid = 1'b0, note_on = 1'b0, phase_reset = 1'b0;
  logic [AW-1:0] fcw_in = '0;
  logic          fcw_ready, sample_tick, phase_valid, active;
  logic [PW-1:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nco_phase_gen #(.ACC_WIDTH(AW), .PHASE_WIDTH(PW), .SAMPLE_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .fcw_in      (fcw_in),
    .fcw_valid   (fcw_valid),
    .fcw_ready   (fcw_ready),
    .note_on     (note_on),
    .phase_reset (phase_reset),
    .sample_tick (sample_tick),
    .phase       (phase),
    .phase_valid (phase_valid),
    .active      (active)
  );

  // Behavioural reference: sample clock count, note state and the two FCW slots.
  int            m_cnt = 0, m_st = S_IDLE;
  longint        m_acc = 0, m_fcw = 0, m_shadow = 0;
  bit            m_pend = 0, m_tick_o = 0, m_pv = 0;
  logic [PW-1:0] m_phase = '0;

  task automatic model_step();
    bit tk, carry;
    longint sum, n_acc;
    int n_st;
    if (rst) begin
      m_cnt = 0; m_st = S_IDLE; m_acc = 0; m_fcw = 0; m_shadow = 0;
      m_pend = 0; m_tick_o = 0; m_pv = 0; m_phase = '0;
      return;
    end
    tk    = (m_cnt == DIV - 1);
    sum   = m_acc + m_fcw;
    carry = (sum >= MOD);
    sum   = sum % MOD;
    n_acc = m_acc;
    n_st  = m_st;
    if (m_st == S_IDLE) begin
      n_acc = 0;
      if (note_on) n_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (tk) n_acc = sum;
      if (!note_on) n_st = S_DRAIN;
    end else if (note_on) begin
      n_st = S_RUN;
      if (tk) n_acc = sum;
    end else if (tk) begin
      if (carry || m_fcw == 0) begin n_acc = 0; n_st = S_IDLE; end
      else n_acc = sum;
    end
    if (phase_reset) n_acc = 0;
    m_pv     = tk && (m_st != S_IDLE);
    if (m_pv) m_phase = PW'(n_acc / (longint'(1) << (AW - PW)));
    m_tick_o = tk;
    if (tk && m_pend) begin
      m_fcw = m_shadow; m_pend = 0;
    end else if (fcw_valid && !m_pend) begin
      m_shadow = longint'(fcw_in); m_pend = 1;
    end
    m_acc = n_acc;
    m_st  = n_st;
    m_cnt = (m_cnt + 1) % DIV;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model, take the edge, compare every output.
  task automatic cyc();
    logic [31:0] exp_w;
    model_step();
    @(posedge clk);
    #1;
    exp_w = 32'({!m_pend, m_tick_o, m_pv, (m_st != S_IDLE), m_phase});
    check("model{ready,tick,pv,active,phase}",
          32'({fcw_ready, sample_tick, phase_valid, active, phase}), exp_w);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; fcw_valid = 1'b0; note_on = 1'b0; phase_reset = 1'b0;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic wait_pv(input string name);
    int n;
    n = 0;
    do begin cyc(); n++; end while (!phase_valid && n < 20);
    check({name, "_pv_seen"}, 32'(phase_valid), 32'd1);
  endtask

  task automatic load_fcw(input logic [AW-1:0] f);
    int n;
    n = 0;
    fcw_in = f; fcw_valid = 1'b1;
    while (!fcw_ready && n < 20) begin cyc(); n++; end
    check("load_ready", 32'(fcw_ready), 32'd1);
    cyc();
    fcw_valid = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] fcw;
    int            k;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t vt[11];
  logic [PW-1:0] exp_list[5];

  initial begin
    int cnt;
    vt[0]  = '{24'h100000,  0, 15'h0000};
    vt[1]  = '{24'h100000,  1, 15'h0800};
    vt[2]  = '{24'h100000,  2, 15'h1000};
    vt[3]  = '{24'h100000,  3, 15'h1800};
    vt[4]  = '{24'h100000, 15, 15'h7800};
    vt[5]  = '{24'h100000, 16, 15'h0000};
    vt[6]  = '{24'h000300,  3, 15'h0004};
    vt[7]  = '{24'h0001FF,  1, 15'h0000};
    vt[8]  = '{24'h0001FF,  2, 15'h0001};
    vt[9]  = '{24'hFFFFFF,  2, 15'h7FFF};
    vt[10] = '{24'h400000,  4, 15'h0000};

    // Reset values, then the free-running tick.
    do_reset(3);
    check("rst_ready", 32'(fcw_ready), 32'd1);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_pv", 32'(phase_valid), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      cnt += int'(sample_tick);
      check("tick_pos", 32'(sample_tick), 32'((i % 4) == 0));
    end
    check("tick_count", 32'(cnt), 32'd3);

    // Steady increment: pulse 0 is the apply tick, pulse k carries k*fcw.
    foreach (vt[v]) begin
      do_reset(2);
      note_on = 1'b1;
      load_fcw(vt[v].fcw);
      for (int p = 0; p <= vt[v].k; p++) wait_pv("vec");
      check($sformatf("vec%0d_phase", v), 32'(phase), 32'(vt[v].exp));
    end

    // Back-pressure: second offer stalls until the first one is applied.
    do_reset(2);
    note_on = 1'b1;
    fcw_in = 24'h200000; fcw_valid = 1'b1;
    cyc();
    fcw_in = 24'h080000;
    check("bp_stalled", 32'(fcw_ready), 32'd0);
    cnt = 0;
    while (!fcw_ready && cnt < 20) begin cyc(); cnt++; end
    check("bp_stall_len", 32'(cnt), 32'd3);
    cyc();
    fcw_valid = 1'b0;
    wait_pv("bp"); check("bp_step1", 32'(phase), 32'h1000);
    wait_pv("bp"); check("bp_step2", 32'(phase), 32'h1400);
    wait_pv("bp"); check("bp_step3", 32'(phase), 32'h1800);

    // Release at 0x5000: drain to the wrap, then go quiet.
    do_reset(2);
    note_on = 1'b1;
    load_fcw(24'h100000);
    for (int i = 0; i < 20 && phase !== 15'h5000; i++) wait_pv("rel");
    check("rel_start", 32'(phase), 32'h5000);
    note_on = 1'b0;
    exp_list = '{15'h5800, 15'h6000, 15'h6800, 15'h7000, 15'h7800};
    foreach (exp_list[i]) begin
      wait_pv("rel");
      check("rel_phase", 32'(phase), 32'(exp_list[i]));
      check("rel_active", 32'(active), 32'd1);
    end
    wait_pv("rel_end");
    check("rel_end_phase", 32'(phase), 32'd0);
    check("rel_end_active", 32'(active), 32'd0);
    cnt = 0;
    repeat (12) begin cyc(); cnt += int'(phase_valid); end
    check("rel_quiet", 32'(cnt), 32'd0);

    // Re-raise during DRAIN: phase continues without a jump.
    do_reset(2);
    note_on = 1'b1;
    load_fcw(24'h100000);
    repeat (3) wait_pv("rr");
    note_on = 1'b0;
    cyc();
    check("rr_drain_active", 32'(active), 32'd1);
    note_on = 1'b1;
    cyc();
    wait_pv("rr"); check("rr_phase1", 32'(phase), 32'h1800);
    wait_pv("rr"); check("rr_phase2", 32'(phase), 32'h2000);

    // phase_reset coinciding with a tick wins over the accumulation.
    repeat (3) cyc();
    phase_reset = 1'b1;
    cyc();
    phase_reset = 1'b0;
    check("pr_pv", 32'(phase_valid), 32'd1);
    check("pr_phase", 32'(phase), 32'd0);
    wait_pv("pr"); check("pr_next", 32'(phase), 32'h0800);

    // DRAIN with a zero FCW ends on the next tick.
    do_reset(2);
    note_on = 1'b1;
    wait_pv("z");
    note_on = 1'b0;
    cyc();
    check("z_drain_active", 32'(active), 32'd1);
    wait_pv("z");
    check("z_idle", 32'(active), 32'd0);

    // Mid-note reset discards the pending FCW.
    do_reset(2);
    note_on = 1'b1;
    load_fcw(24'h100000);
    repeat (2) wait_pv("mr");
    fcw_in = 24'h200000; fcw_valid = 1'b1;
    cyc();
    fcw_valid = 1'b0;
    check("mr_pending", 32'(fcw_ready), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mr_ready", 32'(fcw_ready), 32'd1);
    check("mr_active", 32'(active), 32'd0);
    check("mr_phase", 32'(phase), 32'd0);
    fcw_in = 24'h080000; fcw_valid = 1'b1;
    cyc();
    fcw_valid = 1'b0;
    check("mr_accept", 32'(fcw_ready), 32'd0);

    // Random traffic against the model.
    do_reset(2);
    repeat (4000) begin
      rst         = ($urandom_range(0, 299) == 0);
      fcw_valid   = ($urandom_range(0, 3) == 0);
      fcw_in      = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom());
      phase_reset = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) note_on = ~note_on;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
